// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - assembles UART bytes into 32-bit words and writes them to instruction memory
// Stops after the HALT word or the last memory slot, then holds o_done until the next start.
module instr_loader #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    MEM_DEPTH  = 32,
   parameter logic [DATA_WIDTH-1:0] HALT_WORD  = 32'hFFFFFFFF
) (
   input  logic                  i_clock,
   input  logic                  i_reset,
   input  logic                  i_start,
   input  logic [7:0]            i_rx_data,
   input  logic                  i_rx_done,
   output logic                  o_loading,
   output logic [DATA_WIDTH-1:0] o_address,
   output logic [DATA_WIDTH-1:0] o_instruccion,
   output logic                  o_done,
   output logic [DATA_WIDTH-1:0] o_word_count
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      WRITE,
      DONE
   } state_t;

   localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_DEPTH - 1);

   state_t                  state;
   logic [1:0]              byte_index;
   // Only the first three bytes are buffered; the fourth goes straight into o_instruccion.
   logic [DATA_WIDTH-9:0]   shift;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state         <= IDLE;
         byte_index    <= 2'd0;
         shift         <= '0;
         o_loading     <= 1'b0;
         o_address     <= '0;
         o_instruccion <= '0;
         o_done        <= 1'b0;
         o_word_count  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (i_start) begin
                  state        <= RECV;
                  byte_index   <= 2'd0;
                  shift        <= '0;
                  o_loading    <= 1'b0;
                  o_address    <= '0;
                  o_done       <= 1'b0;
                  o_word_count <= '0;
               end
            end

            RECV: begin
               if (i_start) begin
                  byte_index   <= 2'd0;
                  shift        <= '0;
                  o_address    <= '0;
                  o_word_count <= '0;
               end else if (i_rx_done) begin
                  shift      <= {shift[DATA_WIDTH-17:0], i_rx_data};
                  byte_index <= byte_index + 2'd1;
                  if (byte_index == 2'd3) begin
                     o_instruccion <= {shift, i_rx_data};
                     o_loading     <= 1'b1;
                     state         <= WRITE;
                  end
               end
            end

            WRITE: begin
               o_loading <= 1'b0;
               if (i_start) begin
                  state        <= RECV;
                  byte_index   <= 2'd0;
                  shift        <= '0;
                  o_address    <= '0;
                  o_word_count <= '0;
               end else begin
                  o_word_count <= o_word_count + 1'b1;
                  if (o_instruccion == HALT_WORD || o_address == LAST_ADDR) begin
                     state  <= DONE;
                     o_done <= 1'b1;
                  end else begin
                     o_address  <= o_address + 1'b1;
                     byte_index <= 2'd0;
                     state      <= RECV;
                  end
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - directed self-checking bench for instr_loader
// Drives bytes on the falling edge and logs every memory write seen on the falling edge.
module tb_instr_loader;

   logic        clock;
   logic        reset;
   logic        start;
   logic [7:0]  rx_data;
   logic        rx_done;
   logic        loading;
   logic [31:0] address;
   logic [31:0] instruccion;
   logic        done;
   logic [31:0] word_count;

   int checks   = 0;
   int failures = 0;

   logic [31:0] wr_addr[$];
   logic [31:0] wr_instr[$];

   instr_loader dut (
      .i_clock       (clock),
      .i_reset       (reset),
      .i_start       (start),
      .i_rx_data     (rx_data),
      .i_rx_done     (rx_done),
      .o_loading     (loading),
      .o_address     (address),
      .o_instruccion (instruccion),
      .o_done        (done),
      .o_word_count  (word_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (loading === 1'b1) begin
         wr_addr.push_back(address);
         wr_instr.push_back(instruccion);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_instr.delete();
   endtask

   task automatic pulse_start();
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_data = b;
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      repeat (16) @(negedge clock);
   endtask

   task automatic send_word(input logic [31:0] w);
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
   endtask

   initial begin
      reset   = 1'b1;
      start   = 1'b0;
      rx_data = 8'h00;
      rx_done = 1'b0;

      // reset state
      @(negedge clock);
      check("rst_loading", {31'd0, loading}, 32'd0);
      check("rst_address", address, 32'd0);
      check("rst_instr", instruccion, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_count", word_count, 32'd0);
      reset = 1'b0;

      // bytes before any start are ignored
      send_word(32'h11223344);
      check("idle_nowrite", 32'(wr_addr.size()), 32'd0);

      // 1: single word, latency of the write strobe
      pulse_start();
      send_byte(8'h20);
      send_byte(8'h08);
      send_byte(8'h00);
      @(negedge clock);
      rx_data = 8'h05;
      rx_done = 1'b1;
      @(negedge clock);
      rx_done = 1'b0;
      check("t1_loading_hi", {31'd0, loading}, 32'd1);
      check("t1_addr_during", address, 32'd0);
      check("t1_instr_during", instruccion, 32'h20080005);
      @(negedge clock);
      check("t1_loading_lo", {31'd0, loading}, 32'd0);
      repeat (4) @(negedge clock);
      check("t1_nwrites", 32'(wr_addr.size()), 32'd1);
      check("t1_count", word_count, 32'd1);
      check("t1_next_addr", address, 32'd1);
      check("t1_done", {31'd0, done}, 32'd0);

      // 2: three words ending in HALT
      clear_log();
      pulse_start();
      send_word(32'h00000013);
      send_word(32'h12345678);
      send_word(32'hFFFFFFFF);
      check("t2_nwrites", 32'(wr_addr.size()), 32'd3);
      if (wr_addr.size() == 3) begin
         check("t2_addr0", wr_addr[0], 32'd0);
         check("t2_addr1", wr_addr[1], 32'd1);
         check("t2_addr2", wr_addr[2], 32'd2);
         check("t2_instr0", wr_instr[0], 32'h00000013);
         check("t2_instr1", wr_instr[1], 32'h12345678);
         check("t2_instr2", wr_instr[2], 32'hFFFFFFFF);
      end
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_count", word_count, 32'd3);
      check("t2_addr_hold", address, 32'd2);

      // 3: fill memory with non-HALT words, then one extra word
      clear_log();
      pulse_start();
      for (int i = 0; i < 32; i++) send_word({8'hA0, 16'h0000, 8'(i)});
      check("t3_done", {31'd0, done}, 32'd1);
      send_word(32'hA0000020);
      check("t3_nwrites", 32'(wr_addr.size()), 32'd32);
      if (wr_addr.size() == 32) begin
         for (int i = 0; i < 32; i++) begin
            check($sformatf("t3_addr%0d", i), wr_addr[i], 32'(i));
            check($sformatf("t3_instr%0d", i), wr_instr[i], {8'hA0, 16'h0000, 8'(i)});
         end
      end
      check("t3_count", word_count, 32'd32);
      check("t3_addr_last", address, 32'd31);

      // 4: abort after two bytes
      clear_log();
      pulse_start();
      send_byte(8'h55);
      send_byte(8'h66);
      pulse_start();
      send_word(32'hAABBCCDD);
      check("t4_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("t4_addr", wr_addr[0], 32'd0);
         check("t4_instr", wr_instr[0], 32'hAABBCCDD);
      end
      check("t4_count", word_count, 32'd1);
      check("t4_done", {31'd0, done}, 32'd0);

      // 5: reset after three bytes clears everything at once
      clear_log();
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      #3;
      reset = 1'b1;
      #1;
      check("t5_instr", instruccion, 32'd0);
      check("t5_address", address, 32'd0);
      check("t5_count", word_count, 32'd0);
      @(negedge clock) reset = 1'b0;
      send_word(32'h0A0B0C0D);
      check("t5_nwrites", 32'(wr_addr.size()), 32'd0);
      check("t5_count_after", word_count, 32'd0);

      // 5b: reset while the write strobe is high drops it asynchronously
      pulse_start();
      send_byte(8'h01);
      send_byte(8'h02);
      send_byte(8'h03);
      @(negedge clock);
      rx_data = 8'h04;
      rx_done = 1'b1;
      @(posedge clock);
      #2;
      check("t5b_loading_hi", {31'd0, loading}, 32'd1);
      rx_done = 1'b0;
      reset   = 1'b1;
      #1;
      check("t5b_loading_lo", {31'd0, loading}, 32'd0);
      check("t5b_instr", instruccion, 32'd0);
      @(negedge clock) reset = 1'b0;

      // 6: bytes in DONE ignored, restart writes from address 0
      pulse_start();
      send_word(32'hFFFFFFFF);
      check("t6_done", {31'd0, done}, 32'd1);
      check("t6_count", word_count, 32'd1);
      clear_log();
      send_word(32'h99887766);
      check("t6_done_nowrite", 32'(wr_addr.size()), 32'd0);
      check("t6_count_hold", word_count, 32'd1);
      pulse_start();
      check("t6_done_clr", {31'd0, done}, 32'd0);
      send_word(32'h01020304);
      check("t6_nwrites", 32'(wr_addr.size()), 32'd1);
      if (wr_addr.size() == 1) begin
         check("t6_addr", wr_addr[0], 32'd0);
         check("t6_instr", wr_instr[0], 32'h01020304);
      end
      check("t6_done_low", {31'd0, done}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
